mod_exp_seq: RTL

MOD_EXP_SEQ -- requirements
Module: mod_exp_seq

---
 rtl/mod_exp_seq_if.sv | 24 ++
 rtl/mod_exp_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mod_exp_seq_if.sv
// Request/response bus between the exponentiation sequencer and a Montgomery multiplier.
// The master issues start pulses with operands; the slave returns a one-cycle done pulse with the product.
interface mod_exp_seq_if #(
  parameter int unsigned bitLen     = 64,
  parameter int unsigned countWidth = 4
);
  logic                  mp_start;
  logic [bitLen-1:0]     mp_a;
  logic [bitLen-1:0]     mp_b;
  logic [bitLen-1:0]     mp_m;
  logic [countWidth-1:0] mp_num_words;
  logic                  mp_done;
  logic [bitLen-1:0]     mp_p;

  modport master (
    output mp_start, mp_a, mp_b, mp_m, mp_num_words,
    input  mp_done, mp_p
  );

  modport slave (
    input  mp_start, mp_a, mp_b, mp_m, mp_num_words,
    output mp_done, mp_p
  );
endinterface

// File: rtl/mod_exp_seq.sv
// Left-to-right binary modular exponentiation sequencer driving an external Montgomery multiplier.
// Scans every exponent bit MSB first, then converts the accumulator out of Montgomery form.
module mod_exp_seq #(
  parameter int unsigned bitLen     = 64,
  parameter int unsigned expLen     = 64,
  parameter int unsigned countWidth = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  go,
  input  logic [bitLen-1:0]     base,
  input  logic [expLen-1:0]     exponent,
  input  logic [bitLen-1:0]     modulus,
  input  logic [bitLen-1:0]     one_mont,
  input  logic [countWidth-1:0] num_words,
  mod_exp_seq_if.master         mp,
  output logic                  busy,
  output logic                  done,
  output logic [bitLen-1:0]     result
);

  localparam int unsigned IDX_W = (expLen > 1) ? $clog2(expLen) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQR_REQ,
    S_SQR_WAIT,
    S_MUL_REQ,
    S_MUL_WAIT,
    S_OUT_REQ,
    S_OUT_WAIT,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [bitLen-1:0]     r_acc;
  logic [bitLen-1:0]     r_base;
  logic [expLen-1:0]     r_exp;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_mp_done_d;
  logic                  r_start;
  logic [bitLen-1:0]     r_mp_a;
  logic [bitLen-1:0]     r_mp_b;
  logic [bitLen-1:0]     r_mp_m;
  logic [countWidth-1:0] r_mp_nw;
  logic                  r_busy;
  logic                  r_done;
  logic [bitLen-1:0]     r_result;

  logic w_take;
  logic w_last;

  // A held-high mp_done is consumed only on its rising edge, so it cannot leak into the next WAIT.
  assign w_take = mp.mp_done & ~r_mp_done_d;
  assign w_last = (r_idx == '0);

  assign mp.mp_start     = r_start;
  assign mp.mp_a         = r_mp_a;
  assign mp.mp_b         = r_mp_b;
  assign mp.mp_m         = r_mp_m;
  assign mp.mp_num_words = r_mp_nw;
  assign busy            = r_busy;
  assign done            = r_done;
  assign result          = r_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_base      <= '0;
      r_exp       <= '0;
      r_idx       <= '0;
      r_mp_done_d <= 1'b0;
      r_start     <= 1'b0;
      r_mp_a      <= '0;
      r_mp_b      <= '0;
      r_mp_m      <= '0;
      r_mp_nw     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
    end else begin
      r_start     <= 1'b0;
      r_done      <= 1'b0;
      r_mp_done_d <= mp.mp_done;

      case (r_state)
        S_IDLE: begin
          if (go) begin
            r_base  <= base;
            r_exp   <= exponent;
            r_acc   <= one_mont;
            r_idx   <= IDX_W'(expLen - 1);
            r_mp_a  <= one_mont;
            r_mp_b  <= one_mont;
            r_mp_m  <= modulus;
            r_mp_nw <= num_words;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_SQR_REQ;
          end
        end

        S_SQR_REQ: r_state <= S_SQR_WAIT;
        S_MUL_REQ: r_state <= S_MUL_WAIT;
        S_OUT_REQ: r_state <= S_OUT_WAIT;

        // Operands for the next request are registered here so they are valid in its REQ cycle.
        S_SQR_WAIT: begin
          if (w_take) begin
            r_acc   <= mp.mp_p;
            r_mp_a  <= mp.mp_p;
            r_start <= 1'b1;
            if (r_exp[r_idx]) begin
              r_mp_b  <= r_base;
              r_state <= S_MUL_REQ;
            end else if (w_last) begin
              r_mp_b  <= bitLen'(1);
              r_state <= S_OUT_REQ;
            end else begin
              r_mp_b  <= mp.mp_p;
              r_idx   <= r_idx - IDX_W'(1);
              r_state <= S_SQR_REQ;
            end
          end
        end

        S_MUL_WAIT: begin
          if (w_take) begin
            r_acc   <= mp.mp_p;
            r_mp_a  <= mp.mp_p;
            r_start <= 1'b1;
            if (w_last) begin
              r_mp_b  <= bitLen'(1);
              r_state <= S_OUT_REQ;
            end else begin
              r_mp_b  <= mp.mp_p;
              r_idx   <= r_idx - IDX_W'(1);
              r_state <= S_SQR_REQ;
            end
          end
        end

        S_OUT_WAIT: begin
          if (w_take) begin
            r_result <= mp.mp_p;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_DONE;
          end
        end

        S_DONE: r_state <= S_IDLE;

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
